// File: rtl/ring_counter_nbit.sv
// ring_counter_nbit
//
// Parameterised N-bit one-hot ring counter. It is built from N D flip-flops
// connected in a loop, with the last flip-flop feeding the first. After reset,
// a single hot bit rotates left by one position on every clock edge, so the
// pattern repeats every N clocks. Use it as a phase or slot sequencer where a
// decoded one-hot state is cheaper than a binary counter plus a decoder.
//
// Parameters:
//   N       ring length and width of result (N >= 2), default 4
//
// Ports:
//   clk     input          clock; all state changes on the rising edge
//   rst     input          synchronous active-high reset; loads bit 0 = 1
//   result  output [N-1:0] ring state; bit i is the Q of flip-flop i
//
// Optional feature:
//   RING_COUNTER_SELF_CORRECT_EN
//     When defined, any state that is not exactly one-hot (all-zero or
//     multi-hot) is replaced by the reset pattern on the next edge.
//     When undefined, the counter only rotates: all-zero stays all-zero, and
//     multi-hot patterns keep rotating.

module ring_counter_nbit #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] result
);

    // Reset pattern: only bit 0 set.
    localparam logic [N-1:0] ResetPat = {{(N-1){1'b0}}, 1'b1};

    // D inputs of the flip-flop chain: each bit takes its lower neighbour,
    // and bit 0 takes bit N-1.
    logic [N-1:0] rotated;
    logic [N-1:0] next_state;

    assign rotated = {result[N-2:0], result[N-1]};

`ifdef RING_COUNTER_SELF_CORRECT_EN
    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
    logic one_hot;

    assign one_hot    = (result != '0) && ((result & (result - ResetPat)) == '0);
    assign next_state = one_hot ? rotated : ResetPat;
`else
    assign next_state = rotated;
`endif

    // One flip-flop per bit. result is taken straight from the Q outputs.
    for (genvar i = 0; i < N; i++) begin : g_ff
        logic q;

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= ResetPat[i];
            end else begin
                q <= next_state[i];
            end
        end

        assign result[i] = q;
    end

endmodule

// File: tb/tb_ring_counter_nbit.sv
module tb_ring_counter_nbit;

    logic       clk;
    logic       rst4;
    logic       rst8;
    logic [3:0] result4;
    logic [7:0] result8;

    int checks;
    int passes;

    // Expected results, pushed when a step is driven and popped after its edge.
    logic [7:0] exp_q[$];

    ring_counter_nbit #(.N(4)) dut4 (
        .clk    (clk),
        .rst    (rst4),
        .result (result4)
    );

    ring_counter_nbit #(.N(8)) dut8 (
        .clk    (clk),
        .rst    (rst8),
        .result (result8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got);
        logic [7:0] exp;
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %b, expected %b", tag, got, exp);
    endtask

    // Apply rst for one edge on the N=4 counter and check the state after it.
    task automatic step4(input string tag, input logic r, input logic [3:0] exp);
        rst4 = r;
        exp_q.push_back({4'b0000, exp});
        @(posedge clk);
        #1;
        check(tag, {4'b0000, result4});
    endtask

    task automatic step8(input string tag, input logic r, input logic [7:0] exp);
        rst8 = r;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(tag, result8);
    endtask

    initial begin
        logic [7:0] walk;
        checks = 0;
        passes = 0;
        rst4   = 1'b1;
        rst8   = 1'b1;
        @(negedge clk);

        // Reset, then one full period.
        step4("reset4", 1'b1, 4'b0001);
        step4("rot1", 1'b0, 4'b0010);
        step4("rot2", 1'b0, 4'b0100);
        step4("rot3", 1'b0, 4'b1000);
        step4("wrap", 1'b0, 4'b0001);
        step4("rot5", 1'b0, 4'b0010);
        step4("rot6", 1'b0, 4'b0100);

        // Reset in the middle of a run.
        step4("midrst", 1'b1, 4'b0001);
        step4("postrst", 1'b0, 4'b0010);

        // Force an all-zero lock-up for one edge.
        force dut4.next_state = 4'b0000;
        step4("force0", 1'b0, 4'b0000);
        release dut4.next_state;
`ifdef RING_COUNTER_SELF_CORRECT_EN
        step4("recover0", 1'b0, 4'b0001);
        step4("resume0", 1'b0, 4'b0010);
`else
        step4("stuck0a", 1'b0, 4'b0000);
        step4("stuck0b", 1'b0, 4'b0000);
        step4("unstick", 1'b1, 4'b0001);
`endif

        // Multi-hot state 0101.
        force dut4.next_state = 4'b0101;
        step4("force5", 1'b0, 4'b0101);
        release dut4.next_state;
`ifdef RING_COUNTER_SELF_CORRECT_EN
        step4("recover5", 1'b0, 4'b0001);
        step4("resume5", 1'b0, 4'b0010);
`else
        step4("multi5a", 1'b0, 4'b1010);
        step4("multi5b", 1'b0, 4'b0101);
`endif

        // Multi-hot state 0011.
        force dut4.next_state = 4'b0011;
        step4("force3", 1'b0, 4'b0011);
        release dut4.next_state;
`ifdef RING_COUNTER_SELF_CORRECT_EN
        step4("recover3", 1'b0, 4'b0001);
        step4("resume3", 1'b0, 4'b0010);
`else
        step4("multi3a", 1'b0, 4'b0110);
        step4("multi3b", 1'b0, 4'b1100);
        step4("multi3c", 1'b0, 4'b1001);
        step4("multi3d", 1'b0, 4'b0011);
`endif
        step4("finalrst", 1'b1, 4'b0001);

        // N = 8: reset, then walk all 8 positions and wrap back to bit 0.
        step8("reset8", 1'b1, 8'b0000_0001);
        walk = 8'b0000_0001;
        for (int i = 1; i <= 8; i++) begin
            walk = {walk[6:0], walk[7]};
            step8($sformatf("walk8_%0d", i), 1'b0, walk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
